wb_initiator: RTL and testbench

Wishbone classic-pipelined master (initiator) that turns single-word requests from a simple valid/ready request port into Wishbone cycles.
It handles stall, ack, err and rty, and returns one response per request.
It is the initiator-side counterpart of the generated Wishbone slave decoders and memory bridges, and drives them from sequencers and test logic.
It supports one outstanding transaction; there is no burst support.

---
 rtl/wb_initiator_pkg.sv | 22 ++
 rtl/wb_initiator_wdog.sv | 32 +++
 rtl/wb_initiator.sv | 181 ++++++++++++++++++
 tb/tb_wb_initiator.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_initiator_pkg.sv
// Shared types and defaults for the Wishbone classic-pipelined initiator.
package wb_initiator_pkg;

   localparam int ADDR_W_DEF    = 8;
   localparam int DATA_W_DEF    = 32;
   localparam int MAX_RETRY_DEF = 3;
   localparam int TIMEOUT_DEF   = 255;
   localparam int WDOG_W        = 16;

   // response codes carried on rsp_err_o
   localparam logic RSP_OK  = 1'b0;
   localparam logic RSP_ERR = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      RETRY,
      RESP
   } t_wbi_state;

endpackage

// File: rtl/wb_initiator_wdog.sv
// Ack-wait watchdog: counts cycles spent waiting on the slave and flags
// expiry on the TIMEOUT-th cycle. Only instantiated with WB_INIT_TIMEOUT_EN.
module wb_initiator_wdog
   import wb_initiator_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
)(
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic run,
   output logic expired
);

   localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(TIMEOUT - 1);

   logic [WDOG_W-1:0] cnt;

   // cycle counter, restarted on every entry to REQ, saturates at the limit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (run && (cnt != LIMIT)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expired = run && (cnt == LIMIT);

endmodule

// File: rtl/wb_initiator.sv
// Wishbone classic-pipelined initiator: one outstanding single-word transfer,
// stall/ack/err/rty handling, one response per request.
// Optional ack-wait timeout enabled by defining WB_INIT_TIMEOUT_EN.
//
// state | meaning
// IDLE  | ready for a request, bus idle
// REQ   | cyc=1 stb=1, waiting for stall to drop
// WAIT  | cyc=1 stb=0, request taken, waiting for ack/err/rty
// RETRY | cyc=0 for one cycle before re-issue, or give up
// RESP  | one-cycle response strobe
module wb_initiator
   import wb_initiator_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int MAX_RETRY = MAX_RETRY_DEF,
   parameter int TIMEOUT   = TIMEOUT_DEF
)(
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic                req_we_i,
   input  logic [ADDR_W-3:0]   req_adr_i,
   input  logic [DATA_W-1:0]   req_dat_i,
   input  logic [DATA_W/8-1:0] req_sel_i,
   output logic                rsp_valid_o,
   output logic [DATA_W-1:0]   rsp_dat_o,
   output logic                rsp_err_o,
   output logic                wb_cyc_o,
   output logic                wb_stb_o,
   output logic                wb_we_o,
   output logic [ADDR_W-1:0]   wb_adr_o,
   output logic [DATA_W/8-1:0] wb_sel_o,
   output logic [DATA_W-1:0]   wb_dat_o,
   input  logic [DATA_W-1:0]   wb_dat_i,
   input  logic                wb_ack_i,
   input  logic                wb_err_i,
   input  logic                wb_rty_i,
   input  logic                wb_stall_i
);

   localparam int RC_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   localparam logic [RC_W-1:0] RC_MAX = RC_W'(MAX_RETRY);

   // elaboration-time guard against parameter sets the datapath cannot honour
   if (DATA_W != 32 || TIMEOUT < 1 || ADDR_W < 3) begin : g_bad_cfg
      $error("wb_initiator: unsupported parameter set");
   end

   t_wbi_state        state_q, state_d;
   logic [RC_W-1:0]   retry_cnt;
   logic              rsp_err_d;
   logic              cyc_d, stb_d, rsp_valid_d;
   logic [DATA_W-1:0] rsp_dat_d;
   logic              accept;
   logic              timeout_hit;

   assign req_ready_o = (state_q == IDLE);
   assign accept      = req_valid_i && req_ready_o;

`ifdef WB_INIT_TIMEOUT_EN
   wb_initiator_wdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk     (clk_i),
      .rst     (rst_i),
      .clr     ((state_d == REQ) && (state_q != REQ)),
      .run     ((state_q == REQ) || (state_q == WAIT)),
      .expired (timeout_hit)
   );
`else
   assign timeout_hit = 1'b0;
`endif

   // state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // next-state decode; err outranks ack, ack outranks rty
   always_comb begin
      state_d   = state_q;
      rsp_err_d = RSP_OK;
      case (state_q)
         IDLE: if (accept) state_d = REQ;
         REQ: begin
            if (!wb_stall_i) begin
               if (wb_err_i) begin
                  state_d   = RESP;
                  rsp_err_d = RSP_ERR;
               end else if (wb_ack_i) begin
                  state_d = RESP;
               end else if (wb_rty_i) begin
                  state_d = RETRY;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (wb_err_i) begin
               state_d   = RESP;
               rsp_err_d = RSP_ERR;
            end else if (wb_ack_i) begin
               state_d = RESP;
            end else if (wb_rty_i) begin
               state_d = RETRY;
            end
         end
         RETRY: begin
            if (retry_cnt < RC_MAX) begin
               state_d = REQ;
            end else begin
               state_d   = RESP;
               rsp_err_d = RSP_ERR;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // abort only when the slave gave no answer this cycle
      if (timeout_hit && ((state_d == REQ) || (state_d == WAIT))) begin
         state_d   = RESP;
         rsp_err_d = RSP_ERR;
      end
   end

   // next values of the registered bus and response outputs
   always_comb begin
      cyc_d       = (state_d == REQ) || (state_d == WAIT);
      stb_d       = (state_d == REQ);
      rsp_valid_d = (state_d == RESP);
      rsp_dat_d   = (rsp_err_d || wb_we_o) ? '0 : wb_dat_i;
   end

   // bus strobes and response outputs
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wb_cyc_o    <= 1'b0;
         wb_stb_o    <= 1'b0;
         rsp_valid_o <= 1'b0;
         rsp_err_o   <= 1'b0;
         rsp_dat_o   <= '0;
      end else begin
         wb_cyc_o    <= cyc_d;
         wb_stb_o    <= stb_d;
         rsp_valid_o <= rsp_valid_d;
         rsp_err_o   <= rsp_valid_d ? rsp_err_d : 1'b0;
         if (rsp_valid_d) rsp_dat_o <= rsp_dat_d;
      end
   end

   // request fields are latched once and reused unchanged for every retry
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wb_we_o  <= 1'b0;
         wb_adr_o <= '0;
         wb_dat_o <= '0;
         wb_sel_o <= '0;
      end else if (accept) begin
         wb_we_o  <= req_we_i;
         wb_adr_o <= {req_adr_i, 2'b00};
         wb_dat_o <= req_dat_i;
         wb_sel_o <= req_sel_i;
      end
   end

   // retry counter, cleared once the response goes out
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         retry_cnt <= '0;
      end else if (state_q == RESP) begin
         retry_cnt <= '0;
      end else if ((state_q == RETRY) && (retry_cnt < RC_MAX)) begin
         retry_cnt <= retry_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_wb_initiator.sv
// Directed, table-driven bench for wb_initiator with a reactive slave model.
module tb_wb_initiator;

   localparam int K_ACK    = 0;
   localparam int K_ERR    = 1;
   localparam int K_ERRACK = 2;
   localparam int K_NONE   = 3;

   logic        clk_i, rst_i;
   logic        req_valid_i, req_ready_o, req_we_i;
   logic [5:0]  req_adr_i;
   logic [31:0] req_dat_i;
   logic [3:0]  req_sel_i;
   logic        rsp_valid_o, rsp_err_o;
   logic [31:0] rsp_dat_o;
   logic        wb_cyc_o, wb_stb_o, wb_we_o;
   logic [7:0]  wb_adr_o;
   logic [3:0]  wb_sel_o;
   logic [31:0] wb_dat_o, wb_dat_i;
   logic        wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i;

   wb_initiator #(
      .ADDR_W(8), .DATA_W(32), .MAX_RETRY(3), .TIMEOUT(16)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
      .req_adr_i(req_adr_i), .req_dat_i(req_dat_i), .req_sel_i(req_sel_i),
      .rsp_valid_o(rsp_valid_o), .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
      .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
      .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
      .wb_rty_i(wb_rty_i), .wb_stall_i(wb_stall_i)
   );

   typedef struct {
      logic        we;
      logic [5:0]  adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      int          stall;
      int          lat;
      int          kind;
      int          rty_n;
      logic [31:0] rdata;
      logic        hold;
      int          exp_lat;
      logic        exp_err;
      logic [31:0] exp_dat;
      int          exp_acc;
      int          exp_stb;
   } vec_t;

   int checks = 0;
   int errors = 0;
   int cyc_n  = 0;

   // slave model configuration and monitor state
   int          cfg_stall, cfg_lat, cfg_kind, rty_left;
   logic [31:0] cfg_rdata;
   logic        stray;
   int          phase, stall_left, lat_left, gap;
   int          mon_stb_hi, mon_acc, mon_rsp, mon_unstable, mon_badgap;
   logic        exp_we;
   logic [5:0]  exp_adr;
   logic [31:0] exp_dat;
   logic [3:0]  exp_sel;

   vec_t vecs[8];

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   always @(posedge clk_i) cyc_n <= cyc_n + 1;

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "bench time limit");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic slave_respond();
      if (cfg_kind != K_NONE) begin
         phase = 0;
         if (cfg_kind == K_ERRACK) begin
            wb_err_i = 1'b1;
            wb_ack_i = 1'b1;
            wb_dat_i = cfg_rdata;
         end else if (rty_left > 0) begin
            wb_rty_i = 1'b1;
            rty_left--;
         end else if (cfg_kind == K_ERR) begin
            wb_err_i = 1'b1;
         end else begin
            wb_ack_i = 1'b1;
            wb_dat_i = cfg_rdata;
         end
      end
   endtask

   // reactive slave + bus monitor, evaluated 2 time units after each edge
   initial begin
      wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0; wb_stall_i = 0;
      wb_dat_i = 32'hFFFF_0000;
      phase = 0; gap = 0;
      forever begin
         @(posedge clk_i);
         #2;
         wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0; wb_stall_i = 0;
         wb_dat_i = 32'hFFFF_0000;
         if (rst_i) begin
            phase = 0;
         end else if (stray) begin
            wb_ack_i = 1; wb_err_i = 1; wb_rty_i = 1;
         end else begin
            if (!wb_cyc_o) gap++;
            if (wb_stb_o) begin
               mon_stb_hi++;
               if (wb_adr_o !== {exp_adr, 2'b00} || wb_dat_o !== exp_dat ||
                   wb_sel_o !== exp_sel || wb_we_o !== exp_we)
                  mon_unstable++;
               if (phase == 0) begin
                  if (mon_acc > 0 && gap != 1) mon_badgap++;
                  gap = 0;
                  phase = 1;
                  stall_left = cfg_stall;
               end
               if (phase == 1) begin
                  if (stall_left > 0) begin
                     wb_stall_i = 1;
                     stall_left--;
                  end else begin
                     mon_acc++;
                     phase = 2;
                     lat_left = cfg_lat;
                     if (lat_left == 0) slave_respond();
                  end
               end
            end else if (wb_cyc_o && phase == 2) begin
               lat_left--;
               if (lat_left == 0) slave_respond();
            end else if (!wb_cyc_o) begin
               phase = 0;
            end
         end
         if (rsp_valid_o) mon_rsp++;
      end
   end

   task automatic run_txn(input vec_t v, input string tag);
      int t0, budget;
      cfg_stall = v.stall; cfg_lat = v.lat; cfg_kind = v.kind;
      rty_left = v.rty_n; cfg_rdata = v.rdata;
      mon_stb_hi = 0; mon_acc = 0; mon_rsp = 0; mon_unstable = 0; mon_badgap = 0; gap = 0;
      exp_we = v.we; exp_adr = v.adr; exp_dat = v.dat; exp_sel = v.sel;
      req_valid_i = 1; req_we_i = v.we; req_adr_i = v.adr; req_dat_i = v.dat; req_sel_i = v.sel;
      t0 = cyc_n;
      chk({tag, ".ready"}, req_ready_o, 1);
      tick();
      if (v.hold) begin
         req_we_i = ~v.we; req_adr_i = ~v.adr; req_dat_i = ~v.dat; req_sel_i = ~v.sel;
      end else begin
         req_valid_i = 0;
      end
      chk({tag, ".adr"}, wb_adr_o, {v.adr, 2'b00});
      chk({tag, ".stb"}, {wb_cyc_o, wb_stb_o}, 2'b11);
      chk({tag, ".busy"}, req_ready_o, 0);
      budget = 0;
      while (!rsp_valid_o && budget < 200) begin
         tick();
         budget++;
      end
      req_valid_i = 0;
      chk({tag, ".rsp_seen"}, rsp_valid_o, 1);
      chk({tag, ".lat"}, cyc_n - t0, v.exp_lat);
      chk({tag, ".err"}, rsp_err_o, v.exp_err);
      chk({tag, ".dat"}, rsp_dat_o, v.exp_dat);
      chk({tag, ".cyc_low"}, {wb_cyc_o, wb_stb_o}, 2'b00);
      tick();
      chk({tag, ".one_rsp"}, {rsp_valid_o, 31'(mon_rsp)}, 32'd1);
      chk({tag, ".idle"}, req_ready_o, 1);
      chk({tag, ".dat_hold"}, rsp_dat_o, v.exp_dat);
      chk({tag, ".accepts"}, mon_acc, v.exp_acc);
      chk({tag, ".stb_cycles"}, mon_stb_hi, v.exp_stb);
      chk({tag, ".stable"}, mon_unstable, 0);
      chk({tag, ".gaps"}, mon_badgap, 0);
   endtask

   initial begin
      int bad, wait_n;
      vec_t fv;
      rst_i = 1; stray = 0;
      req_valid_i = 0; req_we_i = 0; req_adr_i = '0; req_dat_i = '0; req_sel_i = '0;
      cfg_kind = K_NONE; cfg_lat = 0; cfg_stall = 0; rty_left = 0; cfg_rdata = '0;
      mon_stb_hi = 0; mon_acc = 0; mon_rsp = 0; mon_unstable = 0; mon_badgap = 0;
      exp_we = 0; exp_adr = '0; exp_dat = '0; exp_sel = '0;

      //          we    adr    dat           sel  stl lat kind      rty rdata         hold lat err  exp_dat       acc stb
      vecs[0] = '{1'b0, 6'h05, 32'h0,        4'hF, 0, 0, K_ACK,    0,  32'hDEADBEEF, 1'b0, 2, 1'b0, 32'hDEADBEEF, 1, 1};
      vecs[1] = '{1'b1, 6'h3F, 32'h12345678, 4'hF, 3, 2, K_ACK,    0,  32'h9999AAAA, 1'b1, 7, 1'b0, 32'h0,        1, 4};
      vecs[2] = '{1'b0, 6'h10, 32'h0,        4'hF, 0, 0, K_ERRACK, 0,  32'hCAFEF00D, 1'b0, 2, 1'b1, 32'h0,        1, 1};
      vecs[3] = '{1'b0, 6'h21, 32'h0,        4'hF, 0, 0, K_ACK,    99, 32'h11112222, 1'b0, 9, 1'b1, 32'h0,        4, 4};
      vecs[4] = '{1'b0, 6'h02, 32'h0,        4'hF, 0, 0, K_ACK,    2,  32'h0BADF00D, 1'b0, 6, 1'b0, 32'h0BADF00D, 3, 3};
      vecs[5] = '{1'b1, 6'h00, 32'hA5A5A5A5, 4'h3, 0, 1, K_ERR,    0,  32'h77777777, 1'b0, 3, 1'b1, 32'h0,        1, 1};
      vecs[6] = '{1'b0, 6'h15, 32'h0,        4'hC, 1, 3, K_ACK,    0,  32'h55AA55AA, 1'b0, 6, 1'b0, 32'h55AA55AA, 1, 2};
      vecs[7] = '{1'b0, 6'h3E, 32'h0,        4'hF, 0, 1, K_ACK,    1,  32'h13579BDF, 1'b0, 6, 1'b0, 32'h13579BDF, 2, 2};

      #2;
      chk("rst.ready", req_ready_o, 1);
      chk("rst.bus", {wb_cyc_o, wb_stb_o, wb_we_o}, 3'b000);
      chk("rst.adr", wb_adr_o, 0);
      chk("rst.rsp", {rsp_valid_o, rsp_err_o}, 2'b00);
      chk("rst.rsp_dat", rsp_dat_o, 0);
      #20 rst_i = 0;
      tick();

      for (int i = 0; i < 8; i++) run_txn(vecs[i], $sformatf("v%0d", i));

      // stray ack/err/rty while idle must be ignored
      stray = 1;
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (rsp_valid_o || wb_cyc_o || !req_ready_o) bad++;
      end
      stray = 0;
      tick();
      chk("stray.ignored", bad, 0);

      // slave never answers: hold in WAIT, then async reset mid-cycle
      cfg_kind = K_NONE; cfg_lat = 0; cfg_stall = 0; rty_left = 0;
      mon_rsp = 0; mon_acc = 0; mon_stb_hi = 0;
      exp_we = 0; exp_adr = 6'h11; exp_dat = 32'h0; exp_sel = 4'hF;
      req_valid_i = 1; req_we_i = 0; req_adr_i = 6'h11; req_dat_i = 0; req_sel_i = 4'hF;
      tick();
      req_valid_i = 0;
`ifdef WB_INIT_TIMEOUT_EN
      wait_n = 6;
`else
      wait_n = 1000;
`endif
      bad = 0;
      for (int i = 0; i < wait_n; i++) begin
         tick();
         if (rsp_valid_o) bad++;
      end
      chk("hang.no_rsp", bad, 0);
      chk("hang.wait", {wb_cyc_o, wb_stb_o}, 2'b10);
      #3 rst_i = 1;
      #1;
      chk("arst.bus", {wb_cyc_o, wb_stb_o}, 2'b00);
      chk("arst.ready", req_ready_o, 1);
      chk("arst.rsp", rsp_valid_o, 0);
      #2 rst_i = 0;
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (rsp_valid_o || wb_cyc_o) bad++;
      end
      chk("arst.quiet", bad, 0);
      chk("arst.ready2", req_ready_o, 1);

      fv = '{1'b0, 6'h2A, 32'h0, 4'hF, 0, 1, K_ACK, 0, 32'h600DCAFE, 1'b0, 3, 1'b0, 32'h600DCAFE, 1, 1};
      run_txn(fv, "after_rst");

`ifdef WB_INIT_TIMEOUT_EN
      fv = '{1'b0, 6'h09, 32'h0, 4'hF, 0, 0, K_NONE, 0, 32'h0, 1'b0, 17, 1'b1, 32'h0, 1, 1};
      run_txn(fv, "timeout");
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
